// File: rtl/cache_ram_sched.sv
// cache_ram_sched -- shares one external RAM port between two cache requesters.
//
// Requester 0 is the instruction cache and requester 1 is the data cache. Each
// transaction moves one 64-byte block as BEATS beats of DATA_W bits. A
// transaction is either a refill (read) or a dirty-block writeback (write).
// Arbitration is round-robin. The owner keeps the port until its whole burst
// completes.
//
// Optional build macro:
//   WB_PRIORITY_EN  When defined, a writeback beats a refill in a tie, so a
//                   dirty victim is always freed before a refill starts.
//                   Ties between two refills or two writebacks still use
//                   round-robin.
//
// Ports:
//   clk, rst_n              clock (rising edge); asynchronous active-low reset
//   rN_req/we/addr/wdata    requester N: request, write flag, block address,
//                           current write beat
//   rN_gnt                  high for the whole burst owned by requester N
//   rN_rvalid               one-cycle pulse; rdata holds a refill beat
//   rN_wack                 one-cycle pulse; current write beat accepted
//   rN_done                 one-cycle pulse after the last beat
//   rdata                   registered copy of ram_in, shared by both requesters
//   ram_req/we/address/wdata  beat request to the RAM
//   ram_ready, ram_in       RAM finishes the beat; read data for that beat
module cache_ram_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int BEATS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r1_req,
  input  logic              r0_we,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r0_gnt,
  output logic              r1_gnt,
  output logic              r0_rvalid,
  output logic              r1_rvalid,
  output logic              r0_wack,
  output logic              r1_wack,
  output logic              r0_done,
  output logic              r1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_req,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic              ram_ready,
  input  logic [DATA_W-1:0] ram_in
);

  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = BEAT_W + BYTE_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t                   state, state_n;
  logic                     owner;     // 0 = requester 0, 1 = requester 1
  logic                     we_q;
  logic                     rr_last;   // requester that owned the last burst
  logic                     rvalid_q;
  logic                     wack_q;
  logic [ADDR_W-OFF_W-1:0]  blk_q;
  logic [BEAT_W-1:0]        beat;
  logic                     any_req;
  logic                     winner;
  logic                     in_burst;
  logic                     beat_done;

  // The offset bits of the block addresses carry no information.
  logic unused_addr;
  assign unused_addr = ^{r0_addr[OFF_W-1:0], r1_addr[OFF_W-1:0]};

  assign any_req   = r0_req | r1_req;
  assign in_burst  = (state == BURST);
  // ram_ready counts only while a beat is actually requested.
  assign beat_done = in_burst & ram_ready;

  // Winner selection. A lone requester wins outright. In a tie, the requester
  // that did not own the previous burst wins.
  always_comb begin
    // NOTE: always_comb outputs get a default before any branch. Without it,
    // a path that skips the assignment would infer a latch.
    winner = r1_req;
    if (r0_req && r1_req) begin
`ifdef WB_PRIORITY_EN
      if (r0_we != r1_we) winner = r1_we;
      else                winner = ~rr_last;
`else
      winner = ~rr_last;
`endif
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = BURST;
      BURST:   if (beat_done && beat == LAST_BEAT) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      rr_last  <= 1'b1;
      rvalid_q <= 1'b0;
      wack_q   <= 1'b0;
      blk_q    <= '0;
      beat     <= '0;
      rdata    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then sees pre-edge values, whatever order the statements are in.
      state    <= state_n;
      rvalid_q <= beat_done & ~we_q;
      wack_q   <= beat_done & we_q;
      if (state == IDLE && any_req) begin
        owner <= winner;
        we_q  <= winner ? r1_we : r0_we;
        blk_q <= winner ? r1_addr[ADDR_W-1:OFF_W] : r0_addr[ADDR_W-1:OFF_W];
        beat  <= '0;
      end
      if (beat_done) begin
        beat <= beat + 1'b1;
        if (!we_q) rdata <= ram_in;
      end
      if (state == DONE) rr_last <= owner;
    end
  end

  // All requester-facing outputs come straight from state. The owner is
  // fixed from grant until the cycle after DONE, so the pulses that trail
  // the last beat still steer to the right requester.
  assign r0_gnt    = in_burst & ~owner;
  assign r1_gnt    = in_burst & owner;
  assign r0_rvalid = rvalid_q & ~owner;
  assign r1_rvalid = rvalid_q & owner;
  assign r0_wack   = wack_q & ~owner;
  assign r1_wack   = wack_q & owner;
  assign r0_done   = (state == DONE) & ~owner;
  assign r1_done   = (state == DONE) & owner;

  assign ram_req     = in_burst;
  assign ram_we      = in_burst & we_q;
  assign ram_address = in_burst ? {blk_q, beat, {BYTE_W{1'b0}}} : '0;
  assign ram_wdata   = ram_we ? (owner ? r1_wdata : r0_wdata) : '0;

endmodule

// File: tb/tb_cache_ram_sched.sv
`timescale 1ns/1ps
module tb_cache_ram_sched;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int BEATS  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              r0_req, r1_req, r0_we, r1_we;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic              r0_wack, r1_wack, r0_done, r1_done;
  logic [DATA_W-1:0] rdata;
  logic              ram_req, ram_we;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_ready;
  logic [DATA_W-1:0] ram_in;

  always #5 clk = ~clk;

  cache_ram_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r1_req(r1_req), .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr), .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_wack(r0_wack), .r1_wack(r1_wack), .r0_done(r0_done), .r1_done(r1_done),
    .rdata(rdata), .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_ready(ram_ready), .ram_in(ram_in)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Requester-side stimulus state.
  logic [1:0]  busy, dropped, txn_we;
  logic [31:0] txn_addr [2];
  logic [63:0] wseed [2];
  int          widx [2];
  // RAM model controls.
  int          rdy_mode;     // 0 always ready, 1 every other burst cycle, 2 random
  logic        ram_in_beat;  // 1: ram_in = beat index, 0: ram_in = data_fn(address)
  logic        prev_req;
  logic        auto_en;
  // Observations taken at the falling edge.
  logic [1:0]  obs_gnt, obs_wk, obs_dn;
  int          cnt_rv [2];
  int          cnt_wk [2];
  int          cnt_dn [2];
  int          cur_len, last_len;
  int          gq [$];
  // Reference model: who owns the port, how many beats are done, and which
  // pulses the next cycle must show.
  int          m_owner, m_beats, m_rr_last;
  logic        m_we;
  logic [31:0] m_base;
  logic [63:0] m_wseed, m_rdata;
  logic [1:0]  m_rv, m_wk, m_dn;

  function automatic logic [63:0] data_fn(input logic [31:0] a);
    return {a ^ 32'hC0DE_0000, ~a};
  endfunction

  function automatic int pick(input logic q0, input logic q1, input logic w0,
                              input logic w1, input int rr);
    if (q0 && !q1) return 0;
    if (q1 && !q0) return 1;
`ifdef WB_PRIORITY_EN
    if (w0 != w1) return w1 ? 1 : 0;
`else
    if (w0 && w1 && !w0) return 0;
`endif
    return (rr == 0) ? 1 : 0;
  endfunction

  task automatic apply_pins();
    r0_req   = busy[0] & ~dropped[0];
    r1_req   = busy[1] & ~dropped[1];
    r0_we    = txn_we[0];
    r1_we    = txn_we[1];
    r0_addr  = txn_addr[0];
    r1_addr  = txn_addr[1];
    r0_wdata = wseed[0] + 64'(widx[0]);
    r1_wdata = wseed[1] + 64'(widx[1]);
  endtask

  task automatic start_txn(input int r, input logic we, input logic [31:0] a,
                           input logic [63:0] s);
    busy[r] = 1'b1; dropped[r] = 1'b0; txn_we[r] = we;
    txn_addr[r] = a; wseed[r] = s; widx[r] = 0;
    apply_pins();
  endtask

  task automatic model_reset();
    m_owner = -1; m_beats = 0; m_rr_last = 1; m_we = 1'b0;
    m_base = '0; m_wseed = '0; m_rdata = '0;
    m_rv = '0; m_wk = '0; m_dn = '0;
    obs_gnt = '0; obs_wk = '0; obs_dn = '0;
    busy = '0; dropped = '0; cur_len = 0;
    apply_pins();
  endtask

  task automatic clr_cnt();
    cnt_rv[0] = 0; cnt_rv[1] = 0; cnt_wk[0] = 0; cnt_wk[1] = 0;
    cnt_dn[0] = 0; cnt_dn[1] = 0; last_len = 0;
    gq.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ctl"}, 64'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_wack, r1_wack,
                              r0_done, r1_done, ram_req, ram_we}), 64'd0);
    check({tag, "_addr"}, 64'(ram_address), 64'd0);
    check({tag, "_wdata"}, ram_wdata, 64'd0);
    check({tag, "_rdata"}, rdata, 64'd0);
  endtask

  // One clock step. Inputs change 1 ns after the rising edge.
  task automatic step();
    @(posedge clk); #1;
    for (int r = 0; r < 2; r++) begin
      if (busy[r]) begin
        if (obs_wk[r]) widx[r]++;
        if (obs_dn[r]) begin
          busy[r] = 1'b0; dropped[r] = 1'b0;
        end else if (auto_en && obs_gnt[r] && $urandom_range(0, 19) == 0) begin
          dropped[r] = 1'b1;
        end
      end else if (auto_en && $urandom_range(0, 3) == 0) begin
        start_txn(r, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
      end
    end
    apply_pins();
    case (rdy_mode)
      0:       ram_ready = 1'b1;
      1:       ram_ready = ram_req & prev_req & ~ram_ready;
      // The requester advances wdata one cycle after wack, so the RAM never
      // completes a beat in a wack cycle.
      default: ram_ready = ($urandom_range(0, 2) != 0) && !(r0_wack || r1_wack);
    endcase
    prev_req = ram_req;
    ram_in = ram_in_beat ? 64'(ram_address[5:3]) : data_fn(ram_address);
  endtask

  task automatic monitor();
    logic [1:0] eg;
    eg = '0;
    if (m_owner >= 0 && m_beats < BEATS) eg[m_owner] = 1'b1;
    check("gnt", 64'({r1_gnt, r0_gnt}), 64'(eg));
    check("ram_req", 64'(ram_req), 64'(|eg));
    check("rvalid", 64'({r1_rvalid, r0_rvalid}), 64'(m_rv));
    check("wack", 64'({r1_wack, r0_wack}), 64'(m_wk));
    check("done", 64'({r1_done, r0_done}), 64'(m_dn));
    if (m_rv != 2'b00) check("rdata", rdata, m_rdata);
    if (eg != 2'b00) begin
      check("ram_address", 64'(ram_address), 64'(m_base + 32'(8 * m_beats)));
      check("ram_we", 64'(ram_we), 64'(m_we));
      if (m_we && ram_ready) check("ram_wdata", ram_wdata, m_wseed + 64'(m_beats));
    end
    cnt_rv[0] += int'(r0_rvalid); cnt_rv[1] += int'(r1_rvalid);
    cnt_wk[0] += int'(r0_wack);   cnt_wk[1] += int'(r1_wack);
    cnt_dn[0] += int'(r0_done);   cnt_dn[1] += int'(r1_done);
    if ((r0_gnt || r1_gnt) && obs_gnt == 2'b00) gq.push_back(r1_gnt ? 1 : 0);
    if (r0_gnt || r1_gnt) cur_len++;
    if (r0_done || r1_done) begin last_len = cur_len; cur_len = 0; end
    obs_gnt = {r1_gnt, r0_gnt};
    obs_wk  = {r1_wack, r0_wack};
    obs_dn  = {r1_done, r0_done};
    // Expectations for the next cycle.
    m_rv = '0; m_wk = '0; m_dn = '0;
    if (eg != 2'b00) begin
      if (ram_ready) begin
        if (m_we) m_wk[m_owner] = 1'b1;
        else begin
          m_rv[m_owner] = 1'b1;
          m_rdata = ram_in_beat ? 64'(m_beats) : data_fn(m_base + 32'(8 * m_beats));
        end
        m_beats++;
        if (m_beats == BEATS) m_dn[m_owner] = 1'b1;
      end
    end else if (m_owner >= 0) begin
      m_rr_last = m_owner;           // done cycle; port idle next cycle
      m_owner = -1;
    end else if (r0_req || r1_req) begin
      m_owner = pick(r0_req, r1_req, r0_we, r1_we, m_rr_last);
      m_beats = 0;
      m_we    = (m_owner == 1) ? r1_we : r0_we;
      m_base  = ((m_owner == 1) ? r1_addr : r0_addr) & ~32'h3F;
      m_wseed = wseed[m_owner];
    end
  endtask

  always @(negedge clk) if (rst_n) monitor();

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    model_reset();
    ram_ready = 1'b0; prev_req = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (busy != 2'b00); i++) step();
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    busy = '0; dropped = '0; txn_we = '0;
    txn_addr[0] = '0; txn_addr[1] = '0; wseed[0] = '0; wseed[1] = '0;
    widx[0] = 0; widx[1] = 0;
    auto_en = 1'b0; rdy_mode = 0; ram_in_beat = 1'b0;
    ram_ready = 1'b0; ram_in = '0; prev_req = 1'b0;
    model_reset(); clr_cnt();
    do_reset();

    // Refill on requester 1; RAM always ready and returns the beat index.
    clr_cnt(); rdy_mode = 0; ram_in_beat = 1'b1;
    start_txn(1, 1'b0, 32'h0000_1234, 64'h0);
    step();
    check("t1_latency", 64'(r1_gnt & ram_req), 64'd1);
    check("t1_first_addr", 64'(ram_address), 64'h1200);
    drain("t1_timeout", 40);
    check("t1_rvalid_cnt", 64'(cnt_rv[1]), 64'd8);
    check("t1_done_cnt", 64'(cnt_dn[1]), 64'd1);
    check("t1_len", 64'(last_len), 64'd8);

    // Writeback on requester 0 with the RAM ready every other cycle.
    clr_cnt(); rdy_mode = 1; ram_in_beat = 1'b0;
    start_txn(0, 1'b1, 32'h0000_0040, 64'hA0);
    drain("t2_timeout", 60);
    check("t2_wack_cnt", 64'(cnt_wk[0]), 64'd8);
    check("t2_done_cnt", 64'(cnt_dn[0]), 64'd1);
    check("t2_len", 64'(last_len), 64'd16);

    // Two simultaneous refill pairs: each pair is served r0 then r1.
    do_reset(); clr_cnt(); rdy_mode = 0;
    start_txn(0, 1'b0, 32'h0000_2000, 64'h0);
    start_txn(1, 1'b0, 32'h0000_3000, 64'h0);
    drain("t3_timeout_a", 80);
    start_txn(0, 1'b0, 32'h0000_2100, 64'h0);
    start_txn(1, 1'b0, 32'h0000_3100, 64'h0);
    drain("t3_timeout_b", 80);
    check("t3_bursts", 64'(gq.size()), 64'd4);
    for (int i = 0; i < gq.size() && i < 4; i++)
      check($sformatf("t3_order%0d", i), 64'(gq[i]), 64'(i % 2));

    // Refill on r0 against writeback on r1, with rr_last at its reset value.
    do_reset(); clr_cnt(); rdy_mode = 2;
    start_txn(0, 1'b0, 32'h0000_4000, 64'h0);
    start_txn(1, 1'b1, 32'h0000_5000, 64'h1111_0000);
    drain("t4_timeout", 120);
`ifdef WB_PRIORITY_EN
    check("t4_first_owner", 64'(gq.size() > 0 ? gq[0] : -1), 64'd1);
`else
    check("t4_first_owner", 64'(gq.size() > 0 ? gq[0] : -1), 64'd0);
`endif

    // Reset asserted mid-refill after beat 3.
    do_reset(); clr_cnt(); rdy_mode = 0;
    start_txn(0, 1'b0, 32'h0000_6000, 64'h0);
    for (int i = 0; i < 30 && cnt_rv[0] < 3; i++) step();
    check("t5_reach_beat3", 64'(cnt_rv[0] >= 3), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("t5_abort");
    model_reset(); ram_ready = 1'b0; prev_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_idle_outputs("t5_hold");
    rst_n = 1'b1;
    start_txn(1, 1'b0, 32'h0000_7000, 64'h0);
    step();
    check("t5_restart_gnt", 64'(r1_gnt), 64'd1);
    check("t5_restart_addr", 64'(ram_address), 64'h7000);
    drain("t5_timeout", 40);

    // ram_ready pulses while idle are ignored; then r0 drops req mid-burst.
    clr_cnt(); rdy_mode = 0;
    repeat (4) step();
    check("t6_idle_rvalid", 64'(cnt_rv[0] + cnt_rv[1]), 64'd0);
    start_txn(0, 1'b0, 32'h0000_8000, 64'h0);
    for (int i = 0; i < 30 && cnt_rv[0] < 2; i++) step();
    dropped[0] = 1'b1;
    apply_pins();
    drain("t6_timeout", 40);
    check("t6_rvalid_cnt", 64'(cnt_rv[0]), 64'd8);
    check("t6_done_cnt", 64'(cnt_dn[0]), 64'd1);

    // Random traffic against the reference model.
    clr_cnt(); rdy_mode = 2; auto_en = 1'b1;
    repeat (3000) step();
    auto_en = 1'b0;
    drain("t7_drain", 200);
    check("t7_done_balance", 64'(cnt_dn[0] + cnt_dn[1] > 0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
